cmd_frame_responder: RTL and testbench

- System-side responder for the UART command protocol. It parses byte frames from the UART receiver and executes register-file writes and reads and ALU operations.
- It pushes response bytes toward the UART transmitter through the TX synchroniser FIFO.
- It sits in the REF_CLK domain between the RX data synchroniser, the register file, the gated ALU and the TX FIFO write side.

---
 rtl/sys_pkg.sv | 27 ++
 rtl/resp_tx_serializer.sv | 44 ++++
 rtl/cmd_frame_responder.sv | 199 +++++++++++++++++++
 tb/tb_cmd_frame_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared constants and FSM state encoding for the UART command responder.
package sys_pkg;

    localparam logic [7:0] RF_WR_CMD   = 8'hAA;
    localparam logic [7:0] RF_RD_CMD   = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;
    localparam logic [7:0] ERR_RESP    = 8'hEE;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_WAIT,
        TX_B0,
        TX_B1
    } state_t;

endpackage

// File: rtl/resp_tx_serializer.sv
// Purpose: holds a 1- or 2-byte response and pushes it LSB first into the TX FIFO.
// Latency: first push strobe is registered, one cycle after the first cycle with the payload loaded and FIFO not full.
// Backpressure: no push is decided while tx_full=1; the payload waits indefinitely.
module resp_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_vld,
    input  logic                    load_two,
    input  logic [2*DATA_WIDTH-1:0] load_dat,
    input  logic                    tx_full,
    output logic                    sent,
    output logic [DATA_WIDTH-1:0]   tx_dat,
    output logic                    tx_vld
);

    logic [2*DATA_WIDTH-1:0] pay_q;
    logic [1:0]              left_q;

    // sent marks the edge at which the current low byte is handed to the FIFO
    assign sent = (left_q != 2'd0) && !tx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            pay_q  <= '0;
            left_q <= 2'd0;
            tx_dat <= '0;
            tx_vld <= 1'b0;
        end else begin
            tx_vld <= sent;
            if (sent) begin
                tx_dat <= pay_q[DATA_WIDTH-1:0];
                pay_q  <= pay_q >> DATA_WIDTH;
                left_q <= left_q - 2'd1;
            end
            if (load_vld) begin
                pay_q  <= load_dat;
                left_q <= load_two ? 2'd2 : 2'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_frame_responder.sv
// Purpose: parses UART command frames, drives register-file/ALU strobes and queues responses (RESP_TIMEOUT_EN adds a wait timeout).
// Latency: strobes appear the cycle after the triggering byte; response pushes start the cycle after data capture.
// Backpressure: TX_FULL stalls the response states indefinitely; RX bytes arriving in wait/response states are dropped.
module cmd_frame_responder
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     RF_ADDR,
    output logic                      RF_WR_EN,
    output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
    output logic                      RF_RD_EN,
    input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
    input  logic                      RF_RD_VLD,
    output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      TX_FULL
);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    resp_two;
    logic                    ser_load;
    logic                    ser_two;
    logic                    ser_sent;
    logic [2*DATA_WIDTH-1:0] ser_payload;
    logic                    timeout_hit;

`ifdef RESP_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 9;

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait     = (state == RD_WAIT) || (state == ALU_WAIT);
    assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST || !in_wait) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A valid always wins over a timeout expiring in the same cycle
    always_comb begin
        ser_load    = 1'b0;
        ser_two     = 1'b0;
        ser_payload = '0;
        if (state == RD_WAIT && RF_RD_VLD) begin
            ser_load    = 1'b1;
            ser_payload = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
        end else if (state == ALU_WAIT && ALU_OUT_VLD) begin
            ser_load    = 1'b1;
            ser_two     = 1'b1;
            ser_payload = ALU_OUT;
        end else if (timeout_hit) begin
            ser_load    = 1'b1;
            ser_payload = {{DATA_WIDTH{1'b0}}, DATA_WIDTH'(ERR_RESP)};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            wr_addr     <= '0;
            resp_two    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            RF_RD_EN    <= 1'b0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            ALU_EN   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == DATA_WIDTH'(RF_WR_CMD)) begin
                            state <= WR_ADDR;
                        end else if (RX_P_DATA == DATA_WIDTH'(RF_RD_CMD)) begin
                            state <= RD_ADDR;
                        end else if (RX_P_DATA == DATA_WIDTH'(ALU_OP_CMD)) begin
                            state <= OP_A;
                        end else if (RX_P_DATA == DATA_WIDTH'(ALU_NOP_CMD)) begin
                            state       <= FUN;
                            CLK_GATE_EN <= 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= wr_addr;
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RD_EN <= 1'b1;
                        RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ser_load) begin
                        resp_two <= ser_two;
                        state    <= TX_B0;
                    end
                end
                OP_A: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN   <= 1'b1;
                        RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
                        RF_WR_DATA <= RX_P_DATA;
                        state      <= OP_B;
                    end
                end
                OP_B: begin
                    if (RX_D_VLD) begin
                        RF_WR_EN    <= 1'b1;
                        RF_ADDR     <= ADDR_WIDTH'(OPB_ADDR);
                        RF_WR_DATA  <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state       <= FUN;
                    end
                end
                FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
                        ALU_EN  <= 1'b1;
                        state   <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    // Gate stays open for one cycle after a real capture, closes at once on timeout
                    if (ser_load) begin
                        resp_two    <= ser_two;
                        CLK_GATE_EN <= ~timeout_hit;
                        state       <= TX_B0;
                    end
                end
                TX_B0: begin
                    CLK_GATE_EN <= 1'b0;
                    if (ser_sent) begin
                        state <= resp_two ? TX_B1 : IDLE;
                    end
                end
                TX_B1: begin
                    if (ser_sent) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    resp_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_tx_serializer (
        .clk      (CLK),
        .rst      (RST),
        .load_vld (ser_load),
        .load_two (ser_two),
        .load_dat (ser_payload),
        .tx_full  (TX_FULL),
        .sent     (ser_sent),
        .tx_dat   (TX_P_DATA),
        .tx_vld   (TX_D_VLD)
    );

endmodule

// File: tb/tb_cmd_frame_responder.sv
// Bench for cmd_frame_responder: command vector table plus hand sequences, with a register-file and ALU
// environment model and queues of expected RF/ALU/TX activity.
module tb_cmd_frame_responder;

    localparam int TIMEOUT_CYCLES = 255;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic [7:0]  RF_WR_DATA;
    logic        RF_RD_EN;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_VLD;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_FULL;

    cmd_frame_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [15:0] exp_tx;
        int          n_tx;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int tx_count = 0;

    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];
    logic [3:0]  alu_q[$];
    logic [7:0]  tx_q[$];

    logic [7:0] rf_mem[16];
    bit         rd_resp_en = 1'b1;
    logic       prev_full  = 1'b0;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        case (fun)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            default: return {a, b};
        endcase
    endfunction

    // Inputs change 1 time unit after the rising edge; every task returns at posedge+1
    task automatic send_byte(input logic [7:0] b, input bit gap);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        if (gap) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((tx_q.size() + wr_q.size() + rd_q.size() + alu_q.size()) != 0 && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL drain: %0d expectations still outstanding after %0d cycles, required 0",
                     tx_q.size() + wr_q.size() + rd_q.size() + alu_q.size(), limit);
            tx_q.delete(); wr_q.delete(); rd_q.delete(); alu_q.delete();
        end
        repeat (4) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        logic [7:0] bytes [4];
        int nb;
        bytes[0] = v.cmd; bytes[1] = v.b1; bytes[2] = v.b2; bytes[3] = v.b3;
        nb = 2;
        case (v.cmd)
            8'hAA: begin
                wr_q.push_back({v.b1[3:0], v.b2});
                nb = 3;
            end
            8'hBB: rd_q.push_back(v.b1[3:0]);
            8'hCC: begin
                wr_q.push_back({4'h0, v.b1});
                wr_q.push_back({4'h1, v.b2});
                alu_q.push_back(v.b3[3:0]);
                nb = 4;
            end
            8'hDD: alu_q.push_back(v.b1[3:0]);
            default: nb = 1;
        endcase
        for (int i = 0; i < v.n_tx; i++) tx_q.push_back(v.exp_tx[8*i +: 8]);
        for (int i = 0; i < nb; i++) send_byte(bytes[i], 1'b1);
        drain(200);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_FUN, ALU_EN,
                     CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'h0);
    endtask

    // Output monitor: RF writes and TX pushes against the scoreboard
    initial begin : monitor
        logic [11:0] exp12;
        logic [7:0]  exp8;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (RF_WR_EN) begin
                    if (wr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rf_wr_unexpected: got addr=0x%0h data=0x%0h, required no write", RF_ADDR, RF_WR_DATA);
                    end else begin
                        exp12 = wr_q.pop_front();
                        check("rf_wr", {RF_ADDR, RF_WR_DATA}, exp12);
                    end
                    rf_mem[RF_ADDR] = RF_WR_DATA;
                end
                if (TX_D_VLD) begin
                    tx_count++;
                    check("tx_while_full", prev_full, 1'b0);
                    if (tx_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_unexpected: got 0x%0h, required no push", TX_P_DATA);
                    end else begin
                        exp8 = tx_q.pop_front();
                        check("tx_byte", TX_P_DATA, exp8);
                    end
                end
            end
            prev_full = TX_FULL;
        end
    end

    // Register-file read port: answers two cycles after RF_RD_EN
    initial begin : rf_responder
        logic [3:0] raddr;
        logic [3:0] exp4;
        RF_RD_VLD  = 1'b0;
        RF_RD_DATA = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST && RF_RD_EN) begin
                raddr = RF_ADDR;
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rf_rd_unexpected: got addr=0x%0h, required no read", RF_ADDR);
                end else begin
                    exp4 = rd_q.pop_front();
                    check("rf_rd_addr", RF_ADDR, exp4);
                end
                if (rd_resp_en) begin
                    @(posedge CLK);
                    @(posedge CLK); #1;
                    RF_RD_DATA = rf_mem[raddr];
                    RF_RD_VLD  = 1'b1;
                    @(posedge CLK); #1;
                    RF_RD_VLD  = 1'b0;
                end
            end
        end
    end

    // ALU: answers three cycles after ALU_EN and checks the clock-gate window
    initial begin : alu_responder
        logic [3:0] fun;
        logic [3:0] exp4;
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'h0000;
        forever begin
            @(negedge CLK);
            if (!RST && ALU_EN) begin
                fun = ALU_FUN;
                check("gate_at_alu_en", CLK_GATE_EN, 1'b1);
                if (alu_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL alu_unexpected: got fun=0x%0h, required no ALU_EN", ALU_FUN);
                end else begin
                    exp4 = alu_q.pop_front();
                    check("alu_fun", ALU_FUN, exp4);
                end
                repeat (3) @(posedge CLK);
                #1;
                ALU_OUT     = alu_model(fun, rf_mem[0], rf_mem[1]);
                ALU_OUT_VLD = 1'b1;
                @(negedge CLK);
                check("gate_in_wait", CLK_GATE_EN, 1'b1);
                @(posedge CLK); #1;
                ALU_OUT_VLD = 1'b0;
                @(negedge CLK);
                check("gate_after_capture", CLK_GATE_EN, 1'b1);
                @(negedge CLK);
                check("gate_closed", CLK_GATE_EN, 1'b0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int tx_before;
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;

        //          cmd    b1     b2     b3     exp_tx     n_tx
        vecs[0]  = '{8'hAA, 8'h0B, 8'h16, 8'h00, 16'h0000, 0};
        vecs[1]  = '{8'hBB, 8'h0B, 8'h00, 8'h00, 16'h0016, 1};
        vecs[2]  = '{8'hCC, 8'h05, 8'h03, 8'h00, 16'h0008, 2};
        vecs[3]  = '{8'hAA, 8'h03, 8'h5A, 8'h00, 16'h0000, 0};
        vecs[4]  = '{8'hBB, 8'h03, 8'h00, 8'h00, 16'h005A, 1};
        vecs[5]  = '{8'hCC, 8'h20, 8'h07, 8'h01, 16'h0019, 2};
        vecs[6]  = '{8'hCC, 8'hF0, 8'h10, 8'h02, 16'h0F00, 2};
        vecs[7]  = '{8'hDD, 8'h03, 8'h00, 8'h00, 16'hF010, 2};
        vecs[8]  = '{8'hAA, 8'h0F, 8'hFF, 8'h00, 16'h0000, 0};
        vecs[9]  = '{8'hBB, 8'h0F, 8'h00, 8'h00, 16'h00FF, 1};
        vecs[10] = '{8'hAA, 8'h1C, 8'h33, 8'h00, 16'h0000, 0};
        vecs[11] = '{8'hBB, 8'h0C, 8'h00, 8'h00, 16'h0033, 1};
        vecs[12] = '{8'hDD, 8'h13, 8'h00, 8'h00, 16'hF010, 2};
        vecs[13] = '{8'hDD, 8'h00, 8'h00, 8'h00, 16'h0100, 2};
        vecs[14] = '{8'hCC, 8'h03, 8'h05, 8'h01, 16'hFFFE, 2};

        RST       = 1'b1;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_FULL   = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("reset_outputs");
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end

        for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

        // Back-to-back: read command arrives the cycle after the write returns to IDLE
        wr_q.push_back({4'h5, 8'h77});
        rd_q.push_back(4'h5);
        tx_q.push_back(8'h77);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h05, 1'b0);
        drain(200);

        // Byte arriving during RD_WAIT is dropped; later non-command bytes are ignored in IDLE
        rd_q.push_back(4'hB);
        tx_q.push_back(8'h16);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'hAA, 1'b1);
        drain(200);
        send_byte(8'h07, 1'b1);
        send_byte(8'h99, 1'b1);
        repeat (5) begin
            @(posedge CLK); #1;
        end
        rd_q.push_back(4'h7);
        tx_q.push_back(8'h00);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h07, 1'b1);
        drain(200);

        // Unknown command in IDLE is ignored
        send_byte(8'h55, 1'b1);
        rd_q.push_back(4'hB);
        tx_q.push_back(8'h16);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h0B, 1'b1);
        drain(200);

        // Reset between write address and data discards the command
        send_byte(8'hAA, 1'b1);
        send_byte(8'h06, 1'b1);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("midcmd_reset_outputs");
        @(posedge CLK); #1;
        RST = 1'b0;
        send_byte(8'h99, 1'b1);
        rd_q.push_back(4'h6);
        tx_q.push_back(8'h00);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h06, 1'b1);
        drain(200);

        // Backpressure: FIFO full across the whole ALU response, then released
        tx_before = tx_count;
        TX_FULL = 1'b1;
        alu_q.push_back(4'h3);
        tx_q.push_back(8'h05);
        tx_q.push_back(8'h03);
        send_byte(8'hDD, 1'b1);
        send_byte(8'h03, 1'b1);
        repeat (14) begin
            @(posedge CLK); #1;
        end
        check("bp_held_bytes", tx_q.size(), 2);
        check("bp_no_push", tx_count - tx_before, 0);
        TX_FULL = 1'b0;
        drain(200);
        check("bp_push_count", tx_count - tx_before, 2);

`ifdef RESP_TIMEOUT_EN
        // Read that never returns data: error byte, then a normal command still works
        rd_resp_en = 1'b0;
        rd_q.push_back(4'h2);
        tx_q.push_back(8'hEE);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h02, 1'b1);
        drain(TIMEOUT_CYCLES + 100);
        rd_resp_en = 1'b1;
        rd_q.push_back(4'hB);
        tx_q.push_back(8'h16);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h0B, 1'b1);
        drain(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
